// File: rtl/flow_meter_emulator_if.sv
// Control and observation bundle between the irrigation controller side and the flow-meter emulator.
// The master drives valve/enable/configuration; the slave (emulator) returns the raw pulse and its status.
interface flow_meter_emulator_if #(
    parameter int GAP_WIDTH    = 8,
    parameter int HIGH_WIDTH   = 8,
    parameter int BOUNCE_WIDTH = 3,
    parameter int CNT_WIDTH    = 6
);
    logic                    enable;
    logic                    valve_on;
    logic                    flow_boost_on;
    logic [GAP_WIDTH-1:0]    gap_cycles;
    logic [HIGH_WIDTH-1:0]   high_cycles;
    logic [BOUNCE_WIDTH-1:0] bounce_n;
    logic                    count_clear;
    logic                    flow_pulse_raw;
    logic [CNT_WIDTH-1:0]    pulse_count;
    logic                    busy;

    modport master (
        output enable, valve_on, flow_boost_on, gap_cycles, high_cycles, bounce_n, count_clear,
        input  flow_pulse_raw, pulse_count, busy
    );

    modport slave (
        input  enable, valve_on, flow_boost_on, gap_cycles, high_cycles, bounce_n, count_clear,
        output flow_pulse_raw, pulse_count, busy
    );
endinterface

// File: rtl/flow_meter_emulator.sv
// Flow-sensor model: emits gap / bouncy-rise / high / bouncy-fall meter pulses while the valve is open.
// Latency: first raw rise eff_gap+1 cycles after enable&&valve_on is sampled; no backpressure (free-running source).
module flow_meter_emulator #(
    parameter int GAP_WIDTH    = 8,
    parameter int HIGH_WIDTH   = 8,
    parameter int BOUNCE_WIDTH = 3,
    parameter int CNT_WIDTH    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    flow_meter_emulator_if.slave  bus
);
    localparam int BW2 = BOUNCE_WIDTH + 1;
    localparam int CW0 = (GAP_WIDTH > HIGH_WIDTH) ? GAP_WIDTH : HIGH_WIDTH;
    localparam int CW  = (CW0 > BW2) ? CW0 : BW2;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GAP    = 3'd1,
        RISE_B = 3'd2,
        HIGH   = 3'd3,
        FALL_B = 3'd4
    } state_t;

    state_t                  state;
    state_t                  nxt;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic [HIGH_WIDTH-1:0]   high_lat;
    logic [BOUNCE_WIDTH-1:0] bounce_lat;
    logic                    latch_cfg;
    logic                    raw_d;
    logic                    finish;
    logic                    go;

    logic                    raw_q;
    logic                    busy_q;
    logic [CNT_WIDTH-1:0]    count_q;

    logic [GAP_WIDTH-1:0]    gap_eff;
    logic [CW-1:0]           gap_load;
    logic [CW-1:0]           high_in_load;
    logic [CW-1:0]           high_lat_load;
    logic [CW-1:0]           bounce_in_load;
    logic [CW-1:0]           bounce_lat_load;

    // Phase counters are loaded with length-1 and count down to zero; zero lengths clamp to one cycle.
    always_comb begin
        gap_eff         = bus.flow_boost_on ? (bus.gap_cycles >> 1) : bus.gap_cycles;
        gap_load        = (gap_eff == '0) ? '0 : CW'(gap_eff - GAP_WIDTH'(1));
        high_in_load    = (bus.high_cycles == '0) ? '0 : CW'(bus.high_cycles - HIGH_WIDTH'(1));
        high_lat_load   = (high_lat == '0) ? '0 : CW'(high_lat - HIGH_WIDTH'(1));
        bounce_in_load  = CW'({bus.bounce_n, 1'b0} - BW2'(1));
        bounce_lat_load = CW'({bounce_lat, 1'b0} - BW2'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        nxt       = state;
        cnt_nxt   = cnt;
        raw_d     = 1'b0;
        finish    = 1'b0;
        latch_cfg = 1'b0;
        go        = bus.enable && bus.valve_on;

        case (state)
            IDLE: begin
                if (go) begin
                    nxt     = GAP;
                    cnt_nxt = gap_load;
                end
            end
            GAP: begin
                if (!bus.valve_on) begin
                    nxt     = IDLE;
                    cnt_nxt = '0;
                end else if (cnt == '0) begin
                    latch_cfg = 1'b1;
                    if (bus.bounce_n == '0) begin
                        nxt     = HIGH;
                        cnt_nxt = high_in_load;
                    end else begin
                        nxt     = RISE_B;
                        cnt_nxt = bounce_in_load;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            RISE_B: begin
                // Count starts odd, so the first bounce cycle is high.
                raw_d = cnt[0];
                if (cnt == '0) begin
                    nxt     = HIGH;
                    cnt_nxt = high_lat_load;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            HIGH: begin
                raw_d = 1'b1;
                if (cnt == '0) begin
                    if (bounce_lat == '0) begin
                        finish = 1'b1;
                    end else begin
                        nxt     = FALL_B;
                        cnt_nxt = bounce_lat_load;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            FALL_B: begin
                raw_d = ~cnt[0];
                if (cnt == '0) begin
                    finish = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end
        endcase

        if (finish) begin
            if (go) begin
                nxt     = GAP;
                cnt_nxt = gap_load;
            end else begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end
        end

        // Disable aborts from any state; a partial pulse is dropped uncounted.
        if (!bus.enable) begin
            nxt     = IDLE;
            cnt_nxt = '0;
            raw_d   = 1'b0;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_lat   <= '0;
            bounce_lat <= '0;
        end else if (latch_cfg) begin
            high_lat   <= bus.high_cycles;
            bounce_lat <= bus.bounce_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q   <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            raw_q  <= raw_d;
            busy_q <= (nxt != IDLE);
            if (bus.count_clear) begin
                count_q <= '0;
            end else if (finish && (count_q != '1)) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.flow_pulse_raw = raw_q;
    assign bus.busy           = busy_q;
    assign bus.pulse_count    = count_q;
endmodule

// File: tb/tb_flow_meter_emulator.sv
// Directed bench for flow_meter_emulator: stimulus posts expected outputs at absolute cycles,
// a negedge monitor pops them in order and compares against the DUT.
module tb_flow_meter_emulator;
    localparam int KIND_RAW  = 0;
    localparam int KIND_CNT  = 1;
    localparam int KIND_BUSY = 2;

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   compared;
    int   mismatched;
    exp_t sb[$];
    exp_t e;
    int   act;
    int   s;

    flow_meter_emulator_if #(.GAP_WIDTH(8), .HIGH_WIDTH(8), .BOUNCE_WIDTH(3), .CNT_WIDTH(6)) bus ();

    flow_meter_emulator #(.GAP_WIDTH(8), .HIGH_WIDTH(8), .BOUNCE_WIDTH(3), .CNT_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(int c, int k, int v, string nm);
        exp_t n;
        int   idx;
        n.cyc  = c;
        n.kind = k;
        n.val  = v;
        n.name = nm;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].cyc > c) idx--;
        sb.insert(idx, n);
    endfunction

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raw level during one bounce=3, gap=20, high=12 pulse, offset from the sample edge.
    function automatic int bounce_raw(int o);
        if (o >= 21 && o <= 26) return (o % 2 == 1) ? 1 : 0;
        if (o >= 27 && o <= 38) return 1;
        if (o >= 39 && o <= 44) return (o % 2 == 0) ? 1 : 0;
        return 0;
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                KIND_RAW: act = int'(bus.flow_pulse_raw);
                KIND_CNT: act = int'(bus.pulse_count);
                default:  act = int'(bus.busy);
            endcase
            compared++;
            if (e.cyc != cyc || act != e.val) begin
                mismatched++;
                $display("FAIL %s @cycle %0d (due %0d): got %0d expected %0d", e.name, cyc, e.cyc, act, e.val);
            end
        end
    end

    initial begin
        #100000;
        mismatched++;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", sb.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        bus.enable        = 1'b0;
        bus.valve_on      = 1'b0;
        bus.flow_boost_on = 1'b0;
        bus.gap_cycles    = '0;
        bus.high_cycles   = '0;
        bus.bounce_n      = '0;
        bus.count_clear   = 1'b0;

        expect_at(1, KIND_RAW,  0, "reset_raw");
        expect_at(1, KIND_CNT,  0, "reset_count");
        expect_at(1, KIND_BUSY, 0, "reset_busy");
        goto(2);
        rst = 1'b0;
        goto(4);

        // Plain pulses, gap 20 / high 12 / no bounce: 32-cycle period, then valve drop in GAP.
        s = cyc + 1;
        for (int p = 0; p < 5; p++) begin
            expect_at(s + 20 + 32*p, KIND_RAW, 0, "t1_raw_pre_rise");
            expect_at(s + 21 + 32*p, KIND_RAW, 1, "t1_raw_rise");
            expect_at(s + 31 + 32*p, KIND_CNT, p, "t1_count_before");
            expect_at(s + 32 + 32*p, KIND_RAW, 1, "t1_raw_last_high");
            expect_at(s + 32 + 32*p, KIND_CNT, p + 1, "t1_count_after");
            expect_at(s + 33 + 32*p, KIND_RAW, 0, "t1_raw_fall");
        end
        expect_at(s + 165, KIND_BUSY, 1, "t4_busy_in_gap");
        expect_at(s + 166, KIND_BUSY, 0, "t4_gap_drop_idle");
        expect_at(s + 166, KIND_CNT,  5, "t4_gap_drop_count");
        expect_at(s + 170, KIND_RAW,  0, "t4_gap_drop_raw");
        bus.gap_cycles  = 8'd20;
        bus.high_cycles = 8'd12;
        bus.bounce_n    = 3'd0;
        bus.enable      = 1'b1;
        bus.valve_on    = 1'b1;
        goto(s + 165);
        bus.valve_on = 1'b0;
        goto(s + 172);

        // Boost halves the gap to 10 (period 22); valve drops mid-HIGH of the third pulse.
        s = cyc + 1;
        expect_at(s,      KIND_CNT, 0, "t2_clear_idle");
        expect_at(s + 10, KIND_RAW, 0, "t2_raw_pre_rise");
        expect_at(s + 11, KIND_RAW, 1, "t2_raw_rise");
        expect_at(s + 22, KIND_CNT, 1, "t2_count1");
        expect_at(s + 23, KIND_RAW, 0, "t2_raw_fall");
        expect_at(s + 33, KIND_RAW, 1, "t2_raw_rise2");
        expect_at(s + 44, KIND_CNT, 2, "t2_count2");
        expect_at(s + 65, KIND_BUSY, 1, "t4_high_drop_busy");
        expect_at(s + 65, KIND_CNT,  2, "t4_high_drop_count_pre");
        expect_at(s + 66, KIND_CNT,  3, "t4_high_drop_counted");
        expect_at(s + 66, KIND_BUSY, 0, "t4_high_drop_idle");
        expect_at(s + 67, KIND_RAW,  0, "t4_high_drop_raw");
        bus.count_clear   = 1'b1;
        bus.flow_boost_on = 1'b1;
        bus.valve_on      = 1'b1;
        goto(s);
        bus.count_clear = 1'b0;
        goto(s + 58);
        bus.valve_on = 1'b0;
        goto(s + 72);

        // Three glitch pairs per edge; enable drops inside the second pulse's rising bounce.
        s = cyc + 1;
        for (int o = 20; o <= 45; o++) expect_at(s + o, KIND_RAW, bounce_raw(o), "t3_bounce_raw");
        expect_at(s + 43, KIND_CNT,  0, "t3_count_pre");
        expect_at(s + 44, KIND_CNT,  1, "t3_count_post");
        expect_at(s + 65, KIND_RAW,  1, "t5_rise_b_raw");
        expect_at(s + 66, KIND_RAW,  0, "t5_abort_raw");
        expect_at(s + 66, KIND_BUSY, 0, "t5_abort_idle");
        expect_at(s + 70, KIND_CNT,  1, "t5_abort_count");
        bus.flow_boost_on = 1'b0;
        bus.bounce_n      = 3'd3;
        bus.count_clear   = 1'b1;
        bus.valve_on      = 1'b1;
        goto(s);
        bus.count_clear = 1'b0;
        goto(s + 65);
        bus.enable = 1'b0;
        goto(s + 72);

        // Asynchronous reset in the middle of HIGH.
        s = cyc + 1;
        expect_at(s + 29, KIND_RAW,  1, "t5_pre_rst_raw");
        expect_at(s + 29, KIND_BUSY, 1, "t5_pre_rst_busy");
        expect_at(s + 29, KIND_CNT,  1, "t5_pre_rst_count");
        expect_at(s + 30, KIND_RAW,  0, "t5_rst_raw");
        expect_at(s + 30, KIND_BUSY, 0, "t5_rst_busy");
        expect_at(s + 30, KIND_CNT,  0, "t5_rst_count");
        bus.enable = 1'b1;
        goto(s + 30);
        rst = 1'b1;
        goto(s + 32);
        bus.enable = 1'b0;
        rst = 1'b0;
        goto(s + 34);

        // Zero/halved-to-zero lengths clamp to 1: 2-cycle period, 70 pulses saturate at 63.
        s = cyc + 1;
        expect_at(s,       KIND_CNT, 0,  "t6_cleared");
        expect_at(s + 1,   KIND_RAW, 0,  "t6_raw_gap");
        expect_at(s + 2,   KIND_RAW, 1,  "t6_raw_high");
        expect_at(s + 2,   KIND_CNT, 1,  "t6_count1");
        expect_at(s + 3,   KIND_RAW, 0,  "t6_raw_gap2");
        expect_at(s + 4,   KIND_CNT, 2,  "t6_count2");
        expect_at(s + 124, KIND_CNT, 62, "t6_count62");
        expect_at(s + 126, KIND_CNT, 63, "t6_count63");
        expect_at(s + 128, KIND_CNT, 63, "t6_sat_hold");
        expect_at(s + 140, KIND_CNT, 63, "t6_sat_70");
        expect_at(s + 141, KIND_CNT, 63, "t6_pre_clear");
        expect_at(s + 142, KIND_CNT, 0,  "t6_clear_on_finish");
        expect_at(s + 143, KIND_CNT, 0,  "t6_after_clear");
        expect_at(s + 144, KIND_CNT, 1,  "t6_recount");
        bus.gap_cycles    = 8'd1;
        bus.flow_boost_on = 1'b1;
        bus.high_cycles   = 8'd0;
        bus.bounce_n      = 3'd0;
        bus.count_clear   = 1'b1;
        bus.enable        = 1'b1;
        bus.valve_on      = 1'b1;
        goto(s);
        bus.count_clear = 1'b0;
        goto(s + 141);
        bus.count_clear = 1'b1;
        goto(s + 142);
        bus.count_clear = 1'b0;
        goto(s + 150);
        bus.enable = 1'b0;
        goto(s + 156);

        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
